// File: rtl/uart_pkg.sv
// Shared types and constants for the UART subsystem.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the slot after
// last_grant sits at bit 0, priority-encode, then un-rotate the winning offset.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      winner,
  output logic               any_req
);

  logic [IW-1:0]        first_s;
  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [IW-1:0]        off_s;
  logic                 found_s;
  logic [IW:0]          sum_s;

  // Rotate, priority-encode and un-rotate with wrap
  always_comb begin
    if (last_grant == IW'(NUM_REQ - 1)) begin
      first_s = '0;
    end else begin
      first_s = last_grant + IW'(1);
    end
    dbl_s   = {req, req} >> first_s;
    rot_s   = dbl_s[NUM_REQ-1:0];
    off_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && rot_s[i]) begin
        off_s   = IW'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    sum_s = {1'b0, first_s} + {1'b0, off_s};
    if (sum_s >= (IW+1)'(NUM_REQ)) begin
      sum_s = sum_s - (IW+1)'(NUM_REQ);
    end else begin
      sum_s = sum_s;
    end
    winner  = sum_s[IW-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers;
// launches each granted byte with a start pulse and tracks the busy flag.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4,
  parameter int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_tx_start,
  output logic [UART_DATA_W-1:0]         o_tx_data,
  input  logic                           i_tx_busy,
  output logic [IW-1:0]                  o_grant_id,
  output logic                           o_active,
  output logic                           o_err_timeout
);

  localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  uart_arb_state_t        state_r, state_s;
  logic [IW-1:0]          last_grant_r, last_grant_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [NUM_REQ-1:0]     ready_r, ready_s;
  logic                   start_r, start_s;
  logic [UART_DATA_W-1:0] data_r, data_s;
  logic [IW-1:0]          grant_r, grant_s;
  logic                   active_r, active_s;
  logic                   err_r, err_s;
  logic [IW-1:0]          winner_s;
  logic                   any_req_s;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req        (i_req_valid),
    .last_grant (last_grant_r),
    .winner     (winner_s),
    .any_req    (any_req_s)
  );

  // Next-state and next-output logic; start and ready default low so they pulse
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    ready_s      = '0;
    start_s      = 1'b0;
    data_s       = data_r;
    grant_s      = grant_r;
    active_s     = active_r;
    err_s        = err_r;
    case (state_r)
      IDLE: begin
        if (any_req_s && !i_tx_busy) begin
          start_s      = 1'b1;
          ready_s      = NUM_REQ'(1) << winner_s;
          data_s       = i_req_data[winner_s*UART_DATA_W +: UART_DATA_W];
          grant_s      = winner_s;
          last_grant_s = winner_s;
          active_s     = 1'b1;
          state_s      = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        cnt_s   = '0;
        state_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_s = WAIT_DONE;
        end else if (cnt_r == CW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte, no retry
          err_s    = 1'b1;
          active_s = 1'b0;
          state_s  = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (i_tx_busy) begin
          state_s = WAIT_DONE;
        end else begin
          active_s = 1'b0;
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= IW'(NUM_REQ - 1);
      cnt_r        <= '0;
      ready_r      <= '0;
      start_r      <= 1'b0;
      data_r       <= '0;
      grant_r      <= '0;
      active_r     <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
      ready_r      <= ready_s;
      start_r      <= start_s;
      data_r       <= data_s;
      grant_r      <= grant_s;
      active_r     <= active_s;
      err_r        <= err_s;
    end
  end

  assign o_req_ready   = ready_r;
  assign o_tx_start    = start_r;
  assign o_tx_data     = data_r;
  assign o_grant_id    = grant_r;
  assign o_active      = active_r;
  assign o_err_timeout = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural transmitter busy model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  typedef struct {
    int        id;
    logic [7:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  valid;
  logic [NR*8-1:0] data;
  logic [NR-1:0]  ready;
  logic           start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;
  logic           err;

  logic           busy_ext;
  logic           no_busy;
  int             frame_len = 10;
  int             busy_cnt;
  int             cyc = 0;
  int             errors = 0;
  int             checks = 0;
  exp_t           exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (valid),
    .i_req_data    (data),
    .o_req_ready   (ready),
    .o_tx_start    (start),
    .o_tx_data     (tx_data),
    .i_tx_busy     (tx_busy),
    .o_grant_id    (grant_id),
    .o_active      (active),
    .o_err_timeout (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises the cycle after start, for frame_len cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (start && !no_busy) busy_cnt <= frame_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = (busy_cnt != 0) || busy_ext;

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start && n < 200);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((active || tx_busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    busy_ext = 1'b0;
    no_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = '0;
    data = '0;
    busy_ext = 1'b0;
    no_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, start, tx_data, grant_id, active, err} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000", {ready, start, tx_data, grant_id, active, err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    int k;
    bit act_bad;
    exp_t e;
    do_reset();
    data[7:0] = 8'h55;
    exp_q.push_back('{0, 8'h55});
    valid = 4'b0001;
    wait_start(n);
    e = exp_q.pop_front();
    checks++;
    if (n !== 1) begin errors++; $display("FAIL single_latency: got %0d want 1", n); end
    checks++;
    if ({ready, tx_data, grant_id, active} !== {4'b0001, e.data, 2'(e.id), 1'b1}) begin
      errors++;
      $display("FAIL single_grant: ready=%b data=%h id=%0d act=%b want 0001 %h %0d 1",
               ready, tx_data, grant_id, active, e.data, e.id);
    end
    @(negedge clk);
    valid = '0;
    checks++;
    if (start !== 1'b0 || ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_pulse_width: start=%b ready=%b want 0 0000", start, ready);
    end
    act_bad = 1'b0;
    k = 0;
    while (tx_busy && k < 50) begin
      if (active !== 1'b1) act_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    checks++;
    if (act_bad || active !== 1'b1 || k < 5) begin
      errors++;
      $display("FAIL single_active_hold: bad=%b act=%b busy_cycles=%0d want 0 1 >=5", act_bad, active, k);
    end
    @(negedge clk);
    checks++;
    if (active !== 1'b0 || tx_data !== 8'h55) begin
      errors++;
      $display("FAIL single_done: act=%b data=%h want 0 55", active, tx_data);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int k;
    int low_cyc;
    exp_t e;
    do_reset();
    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 6; i++) exp_q.push_back('{i % NR, 8'hA0 + 8'(i % NR)});
    valid = 4'b1111;
    for (int f = 0; f < 6; f++) begin
      if (f == 0) begin
        wait_start(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL rr_first_latency: got %0d want 1", n); end
      end else begin
        k = 0;
        do begin @(negedge clk); k++; end while (!tx_busy && k < 50);
        while (tx_busy && k < 100) begin @(negedge clk); k++; end
        low_cyc = cyc;
        wait_start(n);
        checks++;
        if (cyc - low_cyc !== 2) begin
          errors++;
          $display("FAIL rr_b2b_gap frame %0d: got %0d want 2", f, cyc - low_cyc);
        end
      end
      e = exp_q.pop_front();
      checks++;
      if ({ready, tx_data, grant_id} !== {4'(1 << e.id), e.data, 2'(e.id)}) begin
        errors++;
        $display("FAIL rr_grant frame %0d: ready=%b data=%h id=%0d want id %0d data %h",
                 f, ready, tx_data, grant_id, e.id, e.data);
      end
    end
    valid = '0;
    wait_idle();
  endtask

  task automatic test_wrap();
    int n;
    int k;
    bit side_bad;
    exp_t e;
    do_reset();
    data = {8'h33, 8'h22, 8'h11, 8'h00};
    exp_q.push_back('{1, 8'h11});
    exp_q.push_back('{3, 8'h33});
    exp_q.push_back('{1, 8'h11});
    exp_q.push_back('{3, 8'h33});
    valid = 4'b0010;
    side_bad = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_start(n);
      if (f == 0) valid = 4'b1010;
      e = exp_q.pop_front();
      checks++;
      if (n >= 200 || {ready, tx_data, grant_id} !== {4'(1 << e.id), e.data, 2'(e.id)}) begin
        errors++;
        $display("FAIL wrap_grant frame %0d: ready=%b data=%h id=%0d want id %0d", f, ready, tx_data, grant_id, e.id);
      end
      k = 0;
      do begin
        @(negedge clk);
        if (ready[0] || ready[2]) side_bad = 1'b1;
        k++;
      end while ((active || tx_busy) && k < 50);
    end
    checks++;
    if (side_bad) begin errors++; $display("FAIL wrap_no_ready_0_2: got ready on 0/2 want none"); end
    valid = '0;
    wait_idle();
  endtask

  task automatic test_busy_block();
    int n;
    bit started;
    exp_t e;
    do_reset();
    busy_ext = 1'b1;
    data[7:0] = 8'h5A;
    valid = 4'b0001;
    started = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (start) started = 1'b1;
    end
    checks++;
    if (started || active) begin errors++; $display("FAIL busy_block: start=%b act=%b want 0 0", started, active); end
    busy_ext = 1'b0;
    exp_q.push_back('{0, 8'h5A});
    wait_start(n);
    valid = '0;
    e = exp_q.pop_front();
    checks++;
    if (n !== 1 || grant_id !== 2'(e.id) || tx_data !== e.data) begin
      errors++;
      $display("FAIL busy_release: lat=%0d id=%0d data=%h want 1 %0d %h", n, grant_id, tx_data, e.id, e.data);
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    int n;
    exp_t e;
    do_reset();
    no_busy = 1'b1;
    data = {8'h00, 8'h77, 8'h99, 8'h00};
    exp_q.push_back('{2, 8'h77});
    valid = 4'b0100;
    wait_start(n);
    valid = '0;
    e = exp_q.pop_front();
    checks++;
    if (n !== 1 || grant_id !== 2'(e.id) || tx_data !== e.data) begin
      errors++;
      $display("FAIL timeout_grant: lat=%0d id=%0d data=%h want 1 %0d %h", n, grant_id, tx_data, e.id, e.data);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b0 || active !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b act=%b want 0 1", err, active);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || active !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag: err=%b act=%b want 1 0", err, active);
    end
    no_busy = 1'b0;
    exp_q.push_back('{1, 8'h99});
    valid = 4'b0010;
    wait_start(n);
    valid = '0;
    e = exp_q.pop_front();
    checks++;
    if (n !== 1 || grant_id !== 2'(e.id) || tx_data !== e.data || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_regrant: lat=%0d id=%0d data=%h err=%b want 1 %0d %h 1",
               n, grant_id, tx_data, err, e.id, e.data);
    end
    wait_idle();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: err=%b want 1", err); end
  endtask

  task automatic test_async_reset();
    int n;
    exp_t e;
    do_reset();
    data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    exp_q.push_back('{2, 8'hD2});
    valid = 4'b0100;
    wait_start(n);
    valid = '0;
    e = exp_q.pop_front();
    checks++;
    if (n !== 1 || grant_id !== 2'(e.id)) begin
      errors++;
      $display("FAIL areset_pre_grant: lat=%0d id=%0d want 1 %0d", n, grant_id, e.id);
    end
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, start, tx_data, grant_id, active, err} !== 16'h0000) begin
      errors++;
      $display("FAIL areset_outputs: got %h want 0000", {ready, start, tx_data, grant_id, active, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{0, 8'hD0});
    valid = 4'b1111;
    wait_start(n);
    valid = '0;
    e = exp_q.pop_front();
    checks++;
    if (n !== 1 || grant_id !== 2'(e.id) || tx_data !== e.data || ready !== 4'b0001) begin
      errors++;
      $display("FAIL areset_priority: lat=%0d id=%0d data=%h ready=%b want 1 0 d0 0001",
               n, grant_id, tx_data, ready);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_busy_block();
    test_timeout();
    test_async_reset();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
